// File: rtl/l_poly_eval.sv
// rtl/l_poly_eval.sv - pipelined quadratic segment evaluator y = C0 + ((C1 + ((C2*x)>>>XW)) * x)>>>XW
// Five register stages, one request per cycle, saturating 64-bit signed result with sticky flag.
module l_poly_eval #(
  parameter int XW = 24
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_valid,
  input  logic [XW-1:0]     i_xoff,
  input  logic [167:0]      COF_DATA_L,
  input  logic              i_clr_sat,
  output logic              o_valid,
  output logic [63:0]       o_y,
  output logic              o_sat,
  output logic              o_busy
);

  // Control state, cleared by reset
  logic        a_v_q, b_v_q, c_v_q, d_v_q;
  logic        o_valid_q, o_sat_q;
  logic [63:0] o_y_q;

  // Datapath state, qualified by the valid bits only
  logic [XW-1:0]        a_x_q, b_x_q, c_x_q;
  logic signed [48:0]   b_t1_q;
  logic signed [55:0]   b_c1_q;
  logic signed [63:0]   b_c0_q, c_c0_q, d_c0_q;
  logic signed [56:0]   c_s1_q;
  logic signed [57:0]   d_t2_q;

  logic signed [47:0]     c2_w;
  logic signed [XW:0]     a_xs_w, c_xs_w;
  logic signed [48+XW:0]  p1_w;
  logic signed [57+XW:0]  p2_w;
  logic signed [48:0]     t1_d;
  logic signed [56:0]     s1_d;
  logic signed [57:0]     t2_d;
  logic [64:0]            sum_d;
  logic                   ovf_d;
  logic [63:0]            y_d;

  always_comb begin
    c2_w   = COF_DATA_L[47:0];
    a_xs_w = {1'b0, a_x_q};
    c_xs_w = {1'b0, c_x_q};
    p1_w   = c2_w * a_xs_w;
    t1_d   = 49'(p1_w >>> XW);
    s1_d   = {b_c1_q[55], b_c1_q} + {{8{b_t1_q[48]}}, b_t1_q};
    p2_w   = c_s1_q * c_xs_w;
    t2_d   = 58'(p2_w >>> XW);
    sum_d  = {d_c0_q[63], d_c0_q} + {{7{d_t2_q[57]}}, d_t2_q};
    // Top two sum bits disagree only when the 65-bit result leaves the 64-bit range
    ovf_d  = sum_d[64] ^ sum_d[63];
    y_d    = sum_d[63:0];
    if (ovf_d) begin
      y_d = sum_d[64] ? 64'h8000_0000_0000_0000 : 64'h7FFF_FFFF_FFFF_FFFF;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      a_v_q     <= 1'b0;
      b_v_q     <= 1'b0;
      c_v_q     <= 1'b0;
      d_v_q     <= 1'b0;
      o_valid_q <= 1'b0;
      o_y_q     <= 64'd0;
      o_sat_q   <= 1'b0;
    end else begin
      a_v_q     <= i_valid;
      b_v_q     <= a_v_q;
      c_v_q     <= b_v_q;
      d_v_q     <= c_v_q;
      o_valid_q <= d_v_q;
      if (d_v_q) begin
        o_y_q <= y_d;
      end
      if (d_v_q && ovf_d) begin
        o_sat_q <= 1'b1;
      end else if (i_clr_sat) begin
        o_sat_q <= 1'b0;
      end
    end
  end

  // The LUT word is only meaningful in the cycle after a request, so stage B loads on a_v_q
  always_ff @(posedge i_clk) begin
    if (i_valid) begin
      a_x_q <= i_xoff;
    end
    if (a_v_q) begin
      b_t1_q <= t1_d;
      b_c1_q <= COF_DATA_L[103:48];
      b_c0_q <= COF_DATA_L[167:104];
      b_x_q  <= a_x_q;
    end
    if (b_v_q) begin
      c_s1_q <= s1_d;
      c_c0_q <= b_c0_q;
      c_x_q  <= b_x_q;
    end
    if (c_v_q) begin
      d_t2_q <= t2_d;
      d_c0_q <= c_c0_q;
    end
  end

  assign o_valid = o_valid_q;
  assign o_y     = o_y_q;
  assign o_sat   = o_sat_q;
  assign o_busy  = a_v_q | b_v_q | c_v_q | d_v_q;

endmodule

// File: tb/tb_l_poly_eval.sv
// tb/tb_l_poly_eval.sv - self-checking bench for l_poly_eval against an arbitrary-precision reference
module tb_l_poly_eval;

  logic          i_clk = 1'b0;
  logic          i_rst = 1'b1;
  logic          i_valid = 1'b0;
  logic [23:0]   i_xoff = 24'd0;
  logic [167:0]  COF_DATA_L = 168'd0;
  logic          i_clr_sat = 1'b0;
  logic          o_valid;
  logic [63:0]   o_y;
  logic          o_sat;
  logic          o_busy;

  int nerr = 0;
  int nchk = 0;
  int edge_n = 0;

  logic          pend_v = 1'b0;
  logic [167:0]  pend_cof = 168'd0;

  logic [63:0]   got_y[$];
  logic          got_sat[$];
  int            got_cyc[$];

  l_poly_eval #(.XW(24)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .i_xoff(i_xoff),
    .COF_DATA_L(COF_DATA_L), .i_clr_sat(i_clr_sat),
    .o_valid(o_valid), .o_y(o_y), .o_sat(o_sat), .o_busy(o_busy)
  );

  always #5 i_clk = ~i_clk;

  always @(posedge i_clk) edge_n <= edge_n + 1;

  always @(negedge i_clk) begin
    if (o_valid === 1'b1) begin
      got_y.push_back(o_y);
      got_sat.push_back(o_sat);
      got_cyc.push_back(edge_n);
    end
  end

  function automatic logic [167:0] pack(input logic [63:0] c0, input logic [55:0] c1, input logic [47:0] c2);
    return {c0, c1, c2};
  endfunction

  function automatic logic [167:0] rnd168();
    logic [191:0] r;
    r = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
    return r[167:0];
  endfunction

  function automatic logic signed [127:0] fdiv(input logic signed [127:0] a, input logic signed [127:0] b);
    logic signed [127:0] q;
    q = a / b;
    if (a < 0 && (a % b) != 0) q = q - 1;
    return q;
  endfunction

  // Returns {saturated, y}
  function automatic logic [64:0] model(input logic [167:0] cof, input logic [23:0] x);
    logic signed [127:0] c0, c1, c2, xs, d, t1, s1, t2, sum, maxv, minv;
    c0 = {{64{cof[167]}}, cof[167:104]};
    c1 = {{72{cof[103]}}, cof[103:48]};
    c2 = {{80{cof[47]}}, cof[47:0]};
    xs = {104'd0, x};
    d = 128'sd16777216;
    t1 = fdiv(c2 * xs, d);
    s1 = c1 + t1;
    t2 = fdiv(s1 * xs, d);
    sum = c0 + t2;
    maxv = 128'sh7FFF_FFFF_FFFF_FFFF;
    minv = -maxv - 1;
    if (sum > maxv) return {1'b1, maxv[63:0]};
    if (sum < minv) return {1'b1, minv[63:0]};
    return {1'b0, sum[63:0]};
  endfunction

  // Present one cycle of request inputs; the LUT word of the previous request follows one cycle later
  task automatic cyc(input logic v, input logic [23:0] x, input logic [167:0] cof);
    COF_DATA_L = pend_v ? pend_cof : rnd168();
    pend_v = v && !i_rst;
    pend_cof = cof;
    i_valid = v;
    i_xoff = x;
    @(posedge i_clk);
    #1;
  endtask

  task automatic clear_got();
    got_y.delete();
    got_sat.delete();
    got_cyc.delete();
  endtask

  task automatic test_reset();
    i_rst = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (i == 3) i_rst = 1'b0;
      if (i < 3) cyc(1'b1, 24'($urandom()), rnd168());
      else cyc(1'b0, 24'd0, 168'd0);
      nchk++; if (o_valid !== 1'b0) begin nerr++; $display("FAIL reset_valid cyc%0d got=%b exp=0", i, o_valid); end
      nchk++; if (o_y !== 64'd0) begin nerr++; $display("FAIL reset_y cyc%0d got=%h exp=0", i, o_y); end
      nchk++; if (o_sat !== 1'b0) begin nerr++; $display("FAIL reset_sat cyc%0d got=%b exp=0", i, o_sat); end
      nchk++; if (o_busy !== 1'b0) begin nerr++; $display("FAIL reset_busy cyc%0d got=%b exp=0", i, o_busy); end
    end
    nchk++; if (got_y.size() != 0) begin nerr++; $display("FAIL reset_no_output got=%0d exp=0", got_y.size()); end
  endtask

  task automatic test_single();
    int k;
    clear_got();
    cyc(1'b1, 24'hABCDEF, pack(64'd5, 56'd0, 48'd0));
    k = edge_n;
    nchk++; if (o_busy !== 1'b1) begin nerr++; $display("FAIL single_busy step0 got=%b exp=1", o_busy); end
    for (int i = 1; i <= 6; i++) begin
      cyc(1'b0, 24'd0, 168'd0);
      nchk++;
      if (o_busy !== (i <= 3)) begin nerr++; $display("FAIL single_busy step%0d got=%b exp=%b", i, o_busy, (i <= 3)); end
    end
    nchk++; if (got_y.size() != 1) begin nerr++; $display("FAIL single_count got=%0d exp=1", got_y.size()); end
    if (got_y.size() >= 1) begin
      nchk++; if (got_y[0] !== 64'd5) begin nerr++; $display("FAIL single_y got=%h exp=5", got_y[0]); end
      nchk++; if (got_cyc[0] != k + 4) begin nerr++; $display("FAIL single_latency got=%0d exp=%0d", got_cyc[0], k + 4); end
    end
    nchk++; if (o_y !== 64'd5) begin nerr++; $display("FAIL single_hold got=%h exp=5", o_y); end
  endtask

  task automatic test_directed();
    logic [167:0] cofs[3];
    logic [23:0]  xs[3];
    logic [63:0]  ys[3];
    cofs[0] = pack(64'd0, 56'd16777216, 48'd0);        xs[0] = 24'h800000; ys[0] = 64'h0000_0000_0080_0000;
    cofs[1] = pack(64'd0, 56'd0, 48'd16777216);        xs[1] = 24'h800000; ys[1] = 64'h0000_0000_0040_0000;
    cofs[2] = pack(64'd0, 56'd0, 48'hFFFF_FFFF_FFFF);  xs[2] = 24'd1;      ys[2] = 64'hFFFF_FFFF_FFFF_FFFF;
    for (int t = 0; t < 3; t++) begin
      clear_got();
      cyc(1'b1, xs[t], cofs[t]);
      for (int i = 0; i < 6; i++) cyc(1'b0, 24'd0, 168'd0);
      nchk++;
      if (got_y.size() != 1) begin nerr++; $display("FAIL directed%0d_count got=%0d exp=1", t, got_y.size()); end
      else if (got_y[0] !== ys[t]) begin nerr++; $display("FAIL directed%0d_y got=%h exp=%h", t, got_y[0], ys[t]); end
    end
  endtask

  task automatic test_saturation();
    logic [63:0] maxv, minv;
    maxv = 64'h7FFF_FFFF_FFFF_FFFF;
    minv = 64'h8000_0000_0000_0000;
    clear_got();
    cyc(1'b1, 24'd1, pack(maxv, 56'd16777216, 48'd0));
    for (int i = 0; i < 6; i++) cyc(1'b0, 24'd0, 168'd0);
    nchk++; if (got_y.size() != 1 || got_y[0] !== maxv) begin nerr++; $display("FAIL sat_pos_y got=%h exp=%h", o_y, maxv); end
    nchk++; if (got_sat.size() != 1 || got_sat[0] !== 1'b1) begin nerr++; $display("FAIL sat_pos_flag_at_valid exp=1"); end
    for (int i = 0; i < 3; i++) cyc(1'b0, 24'd0, 168'd0);
    nchk++; if (o_sat !== 1'b1) begin nerr++; $display("FAIL sat_sticky got=%b exp=1", o_sat); end
    i_clr_sat = 1'b1;
    cyc(1'b0, 24'd0, 168'd0);
    i_clr_sat = 1'b0;
    nchk++; if (o_sat !== 1'b0) begin nerr++; $display("FAIL sat_clear got=%b exp=0", o_sat); end

    clear_got();
    cyc(1'b1, 24'd1, pack(minv, -56'sd16777216, 48'd0));
    for (int i = 0; i < 6; i++) cyc(1'b0, 24'd0, 168'd0);
    nchk++; if (got_y.size() != 1 || got_y[0] !== minv) begin nerr++; $display("FAIL sat_neg_y got=%h exp=%h", o_y, minv); end
    nchk++; if (o_sat !== 1'b1) begin nerr++; $display("FAIL sat_neg_flag got=%b exp=1", o_sat); end

    // Clear held high across a saturating result: the set must win on the output edge
    i_clr_sat = 1'b1;
    cyc(1'b1, 24'd1, pack(maxv, 56'd16777216, 48'd0));
    for (int i = 1; i <= 3; i++) cyc(1'b0, 24'd0, 168'd0);
    nchk++; if (o_sat !== 1'b0) begin nerr++; $display("FAIL sat_clr_before got=%b exp=0", o_sat); end
    cyc(1'b0, 24'd0, 168'd0);
    nchk++; if (o_sat !== 1'b1 || o_valid !== 1'b1) begin nerr++; $display("FAIL sat_set_wins got=%b/%b exp=1/1", o_sat, o_valid); end
    cyc(1'b0, 24'd0, 168'd0);
    nchk++; if (o_sat !== 1'b0) begin nerr++; $display("FAIL sat_clr_after got=%b exp=0", o_sat); end
    i_clr_sat = 1'b0;
  endtask

  task automatic test_random();
    logic [63:0]  exp_y[$];
    logic         exp_sat[$];
    logic         sticky;
    logic         v;
    logic [23:0]  x;
    logic [167:0] cof;
    logic [64:0]  r;
    int           n;
    clear_got();
    sticky = 1'b0;
    for (int i = 0; i < 300; i++) begin
      v = ($urandom_range(0, 3) != 0);
      x = 24'($urandom());
      case ($urandom_range(0, 7))
        0: x = 24'hFFFFFF;
        1: x = 24'd0;
        default: ;
      endcase
      cof = rnd168();
      case ($urandom_range(0, 7))
        0: cof[167:104] = 64'h7FFF_FFFF_FFFF_FFFF - 64'($urandom_range(0, 1000));
        1: cof[167:104] = 64'h8000_0000_0000_0000 + 64'($urandom_range(0, 1000));
        default: ;
      endcase
      if (v) begin
        r = model(cof, x);
        sticky = sticky | r[64];
        exp_y.push_back(r[63:0]);
        exp_sat.push_back(sticky);
      end
      cyc(v, x, cof);
    end
    for (int i = 0; i < 8; i++) cyc(1'b0, 24'd0, 168'd0);
    nchk++; if (got_y.size() != exp_y.size()) begin nerr++; $display("FAIL random_count got=%0d exp=%0d", got_y.size(), exp_y.size()); end
    n = (got_y.size() < exp_y.size()) ? got_y.size() : exp_y.size();
    for (int i = 0; i < n; i++) begin
      nchk++; if (got_y[i] !== exp_y[i]) begin nerr++; $display("FAIL random_y[%0d] got=%h exp=%h", i, got_y[i], exp_y[i]); end
      nchk++; if (got_sat[i] !== exp_sat[i]) begin nerr++; $display("FAIL random_sat[%0d] got=%b exp=%b", i, got_sat[i], exp_sat[i]); end
    end
    i_clr_sat = 1'b1;
    cyc(1'b0, 24'd0, 168'd0);
    i_clr_sat = 1'b0;
  endtask

  task automatic test_back_to_back();
    clear_got();
    for (int i = 1; i <= 4; i++) cyc(1'b1, 24'($urandom()), pack(64'(i), 56'd0, 48'd0));
    for (int i = 0; i < 6; i++) cyc(1'b0, 24'd0, 168'd0);
    nchk++; if (got_y.size() != 4) begin nerr++; $display("FAIL b2b_count got=%0d exp=4", got_y.size()); end
    for (int i = 0; i < got_y.size() && i < 4; i++) begin
      nchk++; if (got_y[i] !== 64'(i + 1)) begin nerr++; $display("FAIL b2b_y[%0d] got=%h exp=%0d", i, got_y[i], i + 1); end
      nchk++; if (got_cyc[i] != got_cyc[0] + i) begin nerr++; $display("FAIL b2b_consecutive[%0d] got=%0d exp=%0d", i, got_cyc[i], got_cyc[0] + i); end
    end

    clear_got();
    for (int i = 1; i <= 4; i++) cyc(1'b1, 24'($urandom()), pack(64'(i), 56'd0, 48'd0));
    i_rst = 1'b1;
    cyc(1'b0, 24'd0, 168'd0);
    cyc(1'b0, 24'd0, 168'd0);
    i_rst = 1'b0;
    for (int i = 0; i < 6; i++) cyc(1'b0, 24'd0, 168'd0);
    nchk++; if (got_y.size() != 0) begin nerr++; $display("FAIL flush_count got=%0d exp=0", got_y.size()); end
    nchk++; if (o_y !== 64'd0) begin nerr++; $display("FAIL flush_y got=%h exp=0", o_y); end
    nchk++; if (o_busy !== 1'b0) begin nerr++; $display("FAIL flush_busy got=%b exp=0", o_busy); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_directed();
    test_saturation();
    test_random();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule

// File: doc/l_poly_eval.md
L_POLY_EVAL -- requirements
Module: l_poly_eval

Interface
REQ-001 Parameter: XW, default 24, width of the unsigned segment offset i_xoff (fraction Q0.XW); all verification values use XW=24.
REQ-002 i_clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 i_rst  input  1  reset, synchronous, active-high.
REQ-004 i_valid  input  1  request strobe; asserted in the same cycle the 7-bit segment address is presented to the upstream coefficient LUT.
REQ-005 i_xoff  input  XW  unsigned offset within the segment, valid with i_valid.
REQ-006 COF_DATA_L  input  168  coefficient word from the LUT, valid in the cycle after i_valid; fields C0=[167:104] (64b signed), C1=[103:48] (56b signed), C2=[47:0] (48b signed).
REQ-007 i_clr_sat  input  1  clears sticky o_sat.
REQ-008 o_valid  output  1  result strobe, one cycle per accepted request.
REQ-009 o_y  output  64  signed result.
REQ-010 o_sat  output  1  sticky saturation flag.
REQ-011 o_busy  output  1  high while any request is in flight.

Function
REQ-012 Computes y = C0 + ((C1 + ((C2*x)>>>XW)) * x)>>>XW; x = i_xoff zero-extended to XW+1 bits signed; >>> = arithmetic shift, floor rounding.
REQ-013 Stage A (edge k, i_valid sampled high): register i_xoff and valid bit; COF_DATA_L not sampled at edge k.
REQ-014 Stage B (edge k+1): sample COF_DATA_L; register t1 = (C2*x)>>>XW (49b signed), C1, C0, x, valid.
REQ-015 Stage C (edge k+2): register s1 = C1 + t1, sign-extended to 57b (no overflow possible); carry C0, x, valid.
REQ-016 Stage D (edge k+3): register t2 = (s1*x)>>>XW, 58b signed; carry C0, valid.
REQ-017 Stage E (edge k+4): o_y = C0 + t2 evaluated in 65b, saturated to 64b signed range; o_valid = stage D valid.
REQ-018 Latency: i_valid sampled at edge k -> o_valid high and o_y valid in the cycle following edge k+4; fixed, data-independent.
REQ-019 Throughput: one request per cycle; no backpressure; results emerge in request order; back-to-back requests never merge or drop.
REQ-020 o_valid low -> o_y holds its last value.
REQ-021 Saturation: sum > 2^63-1 -> o_y = 64'h7FFF_FFFF_FFFF_FFFF; sum < -2^63 -> o_y = 64'h8000_0000_0000_0000; either sets o_sat at the same edge as o_valid.
REQ-022 o_sat remains high until i_rst or i_clr_sat; set and clear in the same cycle -> set wins.
REQ-023 o_busy = OR of valid bits of stages A-D (combinational from registers).
REQ-024 COF_DATA_L is ignored in any cycle where stage A valid is low (upstream drives entry 0 then).

Reset
REQ-025 i_rst high at an edge: all stage valid bits, o_valid, o_y, o_sat cleared to 0; o_busy 0 the following cycle.
REQ-026 i_valid while i_rst high is discarded; requests in flight when i_rst asserts are flushed and never produce o_valid.
REQ-027 First request accepted at the first edge with i_rst low.

Verification
REQ-028 i_rst=1 for 3 cycles with i_valid=1 -> o_valid=0, o_y=0, o_sat=0, o_busy=0 throughout and for 5 cycles after release with i_valid=0.
REQ-029 C2=0, C1=0, C0=5, i_xoff=24'hABCDEF, single i_valid at edge k -> o_valid exactly once, after edge k+4, o_y=5; o_busy high for 4 cycles.
REQ-030 C2=0, C1=2^24, C0=0, i_xoff=24'h800000 -> o_y=64'h0000_0000_0080_0000.
REQ-031 C2=2^24, C1=0, C0=0, i_xoff=24'h800000 -> o_y=64'h0000_0000_0040_0000; C2=48'hFFFF_FFFF_FFFF, C1=0, C0=0, i_xoff=1 -> o_y=64'hFFFF_FFFF_FFFF_FFFF (floor).
REQ-032 C0=64'h7FFF_FFFF_FFFF_FFFF, C1=2^24, C2=0, i_xoff=1 -> o_y=64'h7FFF_FFFF_FFFF_FFFF, o_sat=1 and held until i_clr_sat pulse, then 0.
REQ-033 Four consecutive i_valid cycles with C0=1,2,3,4 (C1=C2=0) -> four consecutive o_valid cycles, o_y=1,2,3,4 in order; i_rst asserted one cycle after the last request -> no o_valid afterwards.
